mem_forward_unit: RTL and testbench



---
 rtl/mem_forward_unit_pkg.sv | 7 +
 rtl/mem_forward_unit.sv | 60 ++++++
 tb/tb_mem_forward_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_forward_unit_pkg.sv
// Shared pipeline constants for the MEM-stage store-data forwarding logic.
package mem_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

endpackage : mem_forward_unit_pkg

// File: rtl/mem_forward_unit.sv
// Load(WB) -> store(MEM) data-forward detector with a registered select
// and a saturating forwarding-event counter.
module mem_forward_unit #(
  parameter int REG_ADDR_W     = mem_forward_unit_pkg::REG_ADDR_W,
  parameter bit ZERO_REG_GUARD = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] MEM_ADDR,
  input  logic                  MEM_DATA_MEM_WRITE,
  input  logic [REG_ADDR_W-1:0] WB_ADDR,
  input  logic                  WB_DATA_MEM_READ,
  output logic                  MEM_FWD_SEL,
  output logic                  MEM_FWD_SEL_Q,
  output logic [CNT_W-1:0]      FWD_COUNT
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(mem_forward_unit_pkg::ZERO_REG);

  logic             addr_match;
  logic             wb_is_zero;
  logic             fwd_sel;
  logic             sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: pure always_comb with every output assigned on every path, so no latch can form
  // and X/Z inputs simply propagate rather than holding an old value.
  always_comb begin
    addr_match = (MEM_ADDR == WB_ADDR);
    wb_is_zero = (WB_ADDR == ZERO_IDX);
    fwd_sel    = MEM_DATA_MEM_WRITE & WB_DATA_MEM_READ & addr_match
                 & ~(ZERO_REG_GUARD & wb_is_zero);
  end

  // Saturate at all-ones so a long forwarding burst never wraps back to a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (fwd_sel && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sel_q <= fwd_sel;
      cnt_q <= cnt_d;
    end
  end

  assign MEM_FWD_SEL   = fwd_sel;
  assign MEM_FWD_SEL_Q = sel_q;
  assign FWD_COUNT     = cnt_q;

endmodule : mem_forward_unit

// File: tb/tb_mem_forward_unit.sv
// Directed bench for mem_forward_unit: three instances (default, x0 guard off,
// 2-bit counter) share stimulus; expectations are queued then compared.
module tb_mem_forward_unit;
  import mem_forward_unit_pkg::*;

  typedef enum int {
    SIG_SEL, SIG_Q, SIG_CNT, SIG_G0_SEL, SIG_G0_CNT, SIG_C2_SEL, SIG_C2_CNT
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  logic                  CLK;
  logic                  RESET;
  logic [REG_ADDR_W-1:0] MEM_ADDR;
  logic                  MEM_DATA_MEM_WRITE;
  logic [REG_ADDR_W-1:0] WB_ADDR;
  logic                  WB_DATA_MEM_READ;

  logic        sel, sel_q, g0_sel, g0_q, c2_sel, c2_q;
  logic [15:0] cnt, g0_cnt;
  logic [1:0]  c2_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the registered outputs.
  logic        m_q;
  int unsigned m_cnt, m_g0_cnt, m_c2_cnt;

  mem_forward_unit #(.ZERO_REG_GUARD(1'b1), .CNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .MEM_ADDR(MEM_ADDR), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .WB_ADDR(WB_ADDR), .WB_DATA_MEM_READ(WB_DATA_MEM_READ),
    .MEM_FWD_SEL(sel), .MEM_FWD_SEL_Q(sel_q), .FWD_COUNT(cnt));

  mem_forward_unit #(.ZERO_REG_GUARD(1'b0), .CNT_W(16)) u_g0 (
    .CLK(CLK), .RESET(RESET), .MEM_ADDR(MEM_ADDR), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .WB_ADDR(WB_ADDR), .WB_DATA_MEM_READ(WB_DATA_MEM_READ),
    .MEM_FWD_SEL(g0_sel), .MEM_FWD_SEL_Q(g0_q), .FWD_COUNT(g0_cnt));

  mem_forward_unit #(.ZERO_REG_GUARD(1'b1), .CNT_W(2)) u_c2 (
    .CLK(CLK), .RESET(RESET), .MEM_ADDR(MEM_ADDR), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .WB_ADDR(WB_ADDR), .WB_DATA_MEM_READ(WB_DATA_MEM_READ),
    .MEM_FWD_SEL(c2_sel), .MEM_FWD_SEL_Q(c2_q), .FWD_COUNT(c2_cnt));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic model_sel(input logic guard);
    return MEM_DATA_MEM_WRITE && WB_DATA_MEM_READ && (MEM_ADDR == WB_ADDR)
           && !(guard && (WB_ADDR == 5'd0));
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_q      <= 1'b0;
      m_cnt    <= 0;
      m_g0_cnt <= 0;
      m_c2_cnt <= 0;
    end else begin
      m_q <= model_sel(1'b1);
      if (model_sel(1'b1) && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (model_sel(1'b0) && m_g0_cnt < 65535) m_g0_cnt <= m_g0_cnt + 1;
      if (model_sel(1'b1) && m_c2_cnt < 3) m_c2_cnt <= m_c2_cnt + 1;
    end
  end

  task automatic push(input string tag, input sig_e sig, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input sig_e sig);
    case (sig)
      SIG_SEL:    return {15'd0, sel};
      SIG_Q:      return {15'd0, sel_q};
      SIG_CNT:    return cnt;
      SIG_G0_SEL: return {15'd0, g0_sel};
      SIG_G0_CNT: return g0_cnt;
      SIG_C2_SEL: return {15'd0, c2_sel};
      SIG_C2_CNT: return {14'd0, c2_cnt};
      default:    return 16'hxxxx;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs change just after a falling edge so the rising edge always sees stable values.
  task automatic drive(input logic [4:0] ma, input logic wr, input logic [4:0] wa, input logic rd);
    @(negedge CLK);
    MEM_ADDR           = ma;
    MEM_DATA_MEM_WRITE = wr;
    WB_ADDR            = wa;
    WB_DATA_MEM_READ   = rd;
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_regs(input string tag);
    push({tag, "_q"},      SIG_Q,      {15'd0, m_q});
    push({tag, "_cnt"},    SIG_CNT,    m_cnt[15:0]);
    push({tag, "_g0_cnt"}, SIG_G0_CNT, m_g0_cnt[15:0]);
    push({tag, "_c2_cnt"}, SIG_C2_CNT, m_c2_cnt[15:0]);
  endtask

  initial begin
    RESET              = 1'b1;
    MEM_ADDR           = '0;
    MEM_DATA_MEM_WRITE = 1'b0;
    WB_ADDR            = '0;
    WB_DATA_MEM_READ   = 1'b0;
    #2;
    push("rst_q",   SIG_Q,      16'd0);
    push("rst_cnt", SIG_CNT,    16'd0);
    push("rst_c2",  SIG_C2_CNT, 16'd0);
    drain();
    @(negedge CLK);
    RESET = 1'b0;

    drive(5'b11000, 1'b1, 5'b10011, 1'b1);
    push("diff_addr", SIG_SEL, 16'd0);
    drain();
    drive(5'b11000, 1'b1, 5'b01000, 1'b1);
    push("msb_only_diff", SIG_SEL, 16'd0);
    drain();
    drive(5'b11000, 1'b1, 5'b11000, 1'b0);
    push("no_load", SIG_SEL, 16'd0);
    drain();
    drive(5'b11000, 1'b0, 5'b11000, 1'b1);
    push("no_store", SIG_SEL, 16'd0);
    edges(1);
    push_regs("idle");
    drain();

    drive(5'b11000, 1'b1, 5'b11000, 1'b1);
    push("fwd_sel",    SIG_SEL,    16'd1);
    push("fwd_g0_sel", SIG_G0_SEL, 16'd1);
    push("fwd_pre_q",  SIG_Q,      16'd0);
    drain();
    edges(3);
    push("fwd3_q",   SIG_Q,   16'd1);
    push("fwd3_cnt", SIG_CNT, 16'd3);
    push_regs("fwd3");
    drain();

    // Reset pulse between edges while forwarding is still active.
    #1;
    RESET = 1'b1;
    #1;
    push("rst_mid_q",   SIG_Q,   16'd0);
    push("rst_mid_cnt", SIG_CNT, 16'd0);
    push("rst_mid_sel", SIG_SEL, 16'd1);
    drain();
    #1;
    RESET = 1'b0;
    edges(5);
    push("sat_c2_cnt", SIG_C2_CNT, 16'd3);
    push("post_rst_cnt", SIG_CNT,  16'd5);
    push_regs("sat");
    drain();

    drive(5'd0, 1'b1, 5'd0, 1'b1);
    push("x0_guard_sel",   SIG_SEL,    16'd0);
    push("x0_noguard_sel", SIG_G0_SEL, 16'd1);
    push("x0_c2_sel",      SIG_C2_SEL, 16'd0);
    drain();
    edges(2);
    push("x0_q",   SIG_Q,   16'd0);
    push("x0_cnt", SIG_CNT, 16'd5);
    push_regs("x0");
    drain();

    drive(5'd31, 1'b1, 5'd31, 1'b1);
    push("top_reg_sel", SIG_SEL, 16'd1);
    edges(1);
    push_regs("top_reg");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_forward_unit
